bt_uart: RTL and testbench

//   8N1 UART transceiver between the RN41 Bluetooth module's serial pins and the wireless protocol block.
//   RX deserialises bytes from the phone and presents received/rx_byte/recv_error/is_receiving.
//   TX serialises each byte handed over with transmit/tx_byte and reports is_transmitting.

---
 rtl/bt_uart_if.sv | 36 +++
 rtl/bt_uart.sv | 245 ++++++++++++++++++++++++
 tb/tb_bt_uart.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bt_uart_if.sv
`default_nettype none
// ============================================================================
// Module      : bt_uart_if
// Description : Byte-level handshake between the RN41 UART transceiver and
//               the wireless protocol block.
//               master : protocol block (issues transmit/tx_byte, consumes RX)
//               slave  : bt_uart (serialiser / deserialiser)
//   transmit         master->slave  1-cycle request to send tx_byte
//   tx_byte[7:0]     master->slave  byte to send, valid while transmit is high
//   received         slave->master  1-cycle pulse, rx_byte holds a new byte
//   rx_byte[7:0]     slave->master  last good received byte
//   is_receiving     slave->master  RX frame in progress
//   is_transmitting  slave->master  TX frame in progress
//   recv_error       slave->master  1-cycle pulse, framing error
// Revision    : 1.0  initial release
// ============================================================================
interface bt_uart_if;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       received;
    logic [7:0] rx_byte;
    logic       is_receiving;
    logic       is_transmitting;
    logic       recv_error;

    modport master (
        output transmit, tx_byte,
        input  received, rx_byte, is_receiving, is_transmitting, recv_error
    );

    modport slave (
        input  transmit, tx_byte,
        output received, rx_byte, is_receiving, is_transmitting, recv_error
    );
endinterface
`default_nettype wire

// File: rtl/bt_uart.sv
`default_nettype none
// ============================================================================
// Module      : bt_uart
// Description : 8N1 UART transceiver for the RN41 Bluetooth module.
//               RX is oversampled at 16x baud and each bit is sampled at
//               mid-bit; TX shifts out start, 8 data bits LSB first, stop.
// Ports       : clk   in   master clock, rising edge
//               rst   in   synchronous reset, active-high
//               rx    in   serial in from RN41 TX pin (async, idle high)
//               tx    out  serial out to RN41 RX pin (idle high)
//               bus   slave modport of bt_uart_if (byte handshake/status)
// Parameters  : CLK_HZ  master clock frequency, Hz
//               BAUD    line rate, bits/s
// Revision    : 1.0  initial release
// ============================================================================
module bt_uart #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115_200
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rx,
    output logic     tx,
    bt_uart_if.slave bus
);

    // Clocks per 16x tick, rounded to nearest, never below 1.
    localparam int unsigned DIV_RAW = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned c_DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);

    localparam logic [2:0] c_RX_IDLE  = 3'd0;
    localparam logic [2:0] c_RX_START = 3'd1;
    localparam logic [2:0] c_RX_DATA  = 3'd2;
    localparam logic [2:0] c_RX_STOP  = 3'd3;
    localparam logic [2:0] c_RX_BREAK = 3'd4;

    localparam logic [1:0] c_TX_IDLE  = 2'd0;
    localparam logic [1:0] c_TX_START = 2'd1;
    localparam logic [1:0] c_TX_DATA  = 2'd2;
    localparam logic [1:0] c_TX_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // RX
    // ------------------------------------------------------------------
    logic               r_rx_meta;
    logic               r_rx_s;
    logic [2:0]         r_rx_state;
    logic [2:0]         w_rx_state_next;
    logic [c_DIV_W-1:0] r_rx_div;
    logic [3:0]         r_rx_tick;
    logic [2:0]         r_rx_bitcnt;
    logic [7:0]         r_rx_shift;
    logic [7:0]         r_rx_byte;
    logic               r_received;
    logic               r_recv_error;
    logic               w_rx_tick;
    logic               w_rx_mid;
    logic               w_rx_shift_en;
    logic               w_rx_done;
    logic               w_rx_ferr;
    logic               w_is_receiving;

    // Two-flop synchroniser; the raw pin is never used past this point.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_rx_tick = (r_rx_div == c_DIV_LAST);
    // Tick counter is cleared on the start edge, so the count passing
    // 7->8 lands mid start bit and then mid every following bit.
    assign w_rx_mid  = w_rx_tick && (r_rx_tick == 4'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= c_RX_IDLE;
        end else begin
            r_rx_state <= w_rx_state_next;
        end
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        case (r_rx_state)
            c_RX_IDLE:  if (!r_rx_s) w_rx_state_next = c_RX_START;
            c_RX_START: if (w_rx_mid) w_rx_state_next = r_rx_s ? c_RX_IDLE : c_RX_DATA;
            c_RX_DATA:  if (w_rx_mid && (r_rx_bitcnt == 3'd7)) w_rx_state_next = c_RX_STOP;
            c_RX_STOP:  if (w_rx_mid) w_rx_state_next = r_rx_s ? c_RX_IDLE : c_RX_BREAK;
            c_RX_BREAK: if (r_rx_s) w_rx_state_next = c_RX_IDLE;
            default:    w_rx_state_next = c_RX_IDLE;
        endcase
    end

    always_comb begin
        w_rx_shift_en  = (r_rx_state == c_RX_DATA) && w_rx_mid;
        w_rx_done      = (r_rx_state == c_RX_STOP) && w_rx_mid && r_rx_s;
        w_rx_ferr      = (r_rx_state == c_RX_STOP) && w_rx_mid && !r_rx_s;
        w_is_receiving = (r_rx_state != c_RX_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_div     <= '0;
            r_rx_tick    <= '0;
            r_rx_bitcnt  <= '0;
            r_rx_shift   <= '0;
            r_rx_byte    <= '0;
            r_received   <= 1'b0;
            r_recv_error <= 1'b0;
        end else begin
            r_received   <= w_rx_done;
            r_recv_error <= w_rx_ferr;

            if (r_rx_state == c_RX_IDLE) begin
                r_rx_div  <= '0;
                r_rx_tick <= '0;
            end else if (w_rx_tick) begin
                r_rx_div  <= '0;
                r_rx_tick <= r_rx_tick + 4'd1;
            end else begin
                r_rx_div  <= r_rx_div + c_DIV_ONE;
            end

            if (r_rx_state == c_RX_IDLE) begin
                r_rx_bitcnt <= '0;
            end else if (w_rx_shift_en) begin
                r_rx_bitcnt <= r_rx_bitcnt + 3'd1;
            end

            // LSB arrives first, so shift in from the top.
            if (w_rx_shift_en) begin
                r_rx_shift <= {r_rx_s, r_rx_shift[7:1]};
            end

            if (w_rx_done) begin
                r_rx_byte <= r_rx_shift;
            end
        end
    end

    assign bus.received     = r_received;
    assign bus.recv_error   = r_recv_error;
    assign bus.rx_byte      = r_rx_byte;
    assign bus.is_receiving = w_is_receiving;

    // ------------------------------------------------------------------
    // TX
    // ------------------------------------------------------------------
    logic [1:0]         r_tx_state;
    logic [1:0]         w_tx_state_next;
    logic [c_DIV_W-1:0] r_tx_div;
    logic [3:0]         r_tx_tick;
    logic [2:0]         r_tx_bitcnt;
    logic [7:0]         r_tx_shift;
    logic               r_tx;
    logic               w_tx_tick;
    logic               w_tx_bit_end;
    logic               w_tx_accept;
    logic               w_tx_next;
    logic               w_is_transmitting;

    assign w_tx_tick    = (r_tx_div == c_DIV_LAST);
    assign w_tx_bit_end = w_tx_tick && (r_tx_tick == 4'd15);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= c_TX_IDLE;
        end else begin
            r_tx_state <= w_tx_state_next;
        end
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        case (r_tx_state)
            c_TX_IDLE:  if (bus.transmit) w_tx_state_next = c_TX_START;
            c_TX_START: if (w_tx_bit_end) w_tx_state_next = c_TX_DATA;
            c_TX_DATA:  if (w_tx_bit_end && (r_tx_bitcnt == 3'd7)) w_tx_state_next = c_TX_STOP;
            c_TX_STOP:  if (w_tx_bit_end) w_tx_state_next = c_TX_IDLE;
            default:    w_tx_state_next = c_TX_IDLE;
        endcase
    end

    // The line value for the next cycle is decided here so that tx is a
    // clean register output and changes exactly on bit boundaries.
    always_comb begin
        w_tx_accept       = (r_tx_state == c_TX_IDLE) && bus.transmit;
        w_is_transmitting = (r_tx_state != c_TX_IDLE);
        w_tx_next         = r_tx;
        case (r_tx_state)
            c_TX_IDLE:  w_tx_next = !bus.transmit;
            c_TX_START: if (w_tx_bit_end) w_tx_next = r_tx_shift[0];
            c_TX_DATA:  if (w_tx_bit_end) w_tx_next = (r_tx_bitcnt == 3'd7) ? 1'b1 : r_tx_shift[1];
            c_TX_STOP:  if (w_tx_bit_end) w_tx_next = 1'b1;
            default:    w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx        <= 1'b1;
            r_tx_div    <= '0;
            r_tx_tick   <= '0;
            r_tx_bitcnt <= '0;
            r_tx_shift  <= '0;
        end else begin
            r_tx <= w_tx_next;

            if (r_tx_state == c_TX_IDLE) begin
                r_tx_div  <= '0;
                r_tx_tick <= '0;
            end else if (w_tx_tick) begin
                r_tx_div  <= '0;
                r_tx_tick <= r_tx_tick + 4'd1;
            end else begin
                r_tx_div  <= r_tx_div + c_DIV_ONE;
            end

            if (r_tx_state == c_TX_IDLE) begin
                r_tx_bitcnt <= '0;
            end else if ((r_tx_state == c_TX_DATA) && w_tx_bit_end) begin
                r_tx_bitcnt <= r_tx_bitcnt + 3'd1;
            end

            if (w_tx_accept) begin
                r_tx_shift <= bus.tx_byte;
            end else if ((r_tx_state == c_TX_DATA) && w_tx_bit_end) begin
                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
        end
    end

    assign tx                  = r_tx;
    assign bus.is_transmitting = w_is_transmitting;

endmodule
`default_nettype wire

// File: tb/tb_bt_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_bt_uart
// Description : Scoreboard bench for bt_uart at 16 clocks per bit.
//               Expected RX events and TX bytes are queued when stimulus is
//               issued; monitors pop them when the DUT pulses or frames.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bt_uart;
    localparam int unsigned c_CLK_HZ = 1_600_000;
    localparam int unsigned c_BAUD   = 100_000;

    logic clk = 1'b0;
    logic rst;
    logic rx_drv;
    logic loop_en;
    logic tx;
    logic rx;

    bt_uart_if bus();

    assign rx = loop_en ? tx : rx_drv;

    bt_uart #(.CLK_HZ(c_CLK_HZ), .BAUD(c_BAUD)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .tx  (tx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [8:0] rx_q[$];   // {is_error, expected rx_byte}
    logic [7:0] tx_q[$];
    logic [7:0] last_good = 8'h00;
    bit         mon_en    = 1'b1;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // RX scoreboard monitor
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && (bus.received === 1'b1 || bus.recv_error === 1'b1)) begin
                check(!(bus.received && bus.recv_error), "rx_pulse_exclusive",
                      int'({bus.received, bus.recv_error}), 0);
                check(rx_q.size() != 0, "rx_event_expected", rx_q.size(), 1);
                if (rx_q.size() != 0) begin
                    e = rx_q.pop_front();
                    check(bus.recv_error == e[8], "rx_event_kind", int'(bus.recv_error), int'(e[8]));
                    check(bus.rx_byte == e[7:0], "rx_byte", int'(bus.rx_byte), int'(e[7:0]));
                end
            end
        end
    end

    // TX line decoder: samples the serial line at mid-bit like a receiver
    initial begin
        logic [7:0] got;
        logic [7:0] e;
        bit         framing_ok;
        forever begin
            @(negedge clk);
            if (mon_en && rst === 1'b0 && tx === 1'b0) begin
                framing_ok = 1'b1;
                repeat (8) @(negedge clk);
                if (tx !== 1'b0) framing_ok = 1'b0;
                for (int j = 0; j < 8; j++) begin
                    repeat (16) @(negedge clk);
                    got[j] = tx;
                end
                repeat (16) @(negedge clk);
                if (tx !== 1'b1) framing_ok = 1'b0;
                repeat (7) @(negedge clk);
                check(tx_q.size() != 0, "tx_frame_expected", tx_q.size(), 1);
                if (tx_q.size() != 0) begin
                    e = tx_q.pop_front();
                    check(got == e, "tx_byte", int'(got), int'(e));
                end
                check(framing_ok, "tx_framing", int'(framing_ok), 1);
            end
        end
    end

    task automatic send_rx(input logic [7:0] b, input bit stop_ok, input int gap);
        if (stop_ok) begin
            rx_q.push_back({1'b0, b});
            last_good = b;
        end else begin
            rx_q.push_back({1'b1, last_good});
        end
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            rx_drv = b[j];
            repeat (16) @(negedge clk);
        end
        rx_drv = stop_ok;
        repeat (16) @(negedge clk);
        if (!stop_ok) repeat (48) @(negedge clk);
        rx_drv = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_tx(input logic [7:0] b);
        int n;
        n = 0;
        while (bus.is_transmitting && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(!bus.is_transmitting, "tx_wait_idle", int'(bus.is_transmitting), 0);
        bus.transmit = 1'b1;
        bus.tx_byte  = b;
        tx_q.push_back(b);
        if (loop_en) begin
            rx_q.push_back({1'b0, b});
            last_good = b;
        end
        @(negedge clk);
        bus.transmit = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rx_q.size() != 0 || tx_q.size() != 0 || bus.is_transmitting || bus.is_receiving)
               && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        check(rx_q.size() == 0, "rx_queue_drained", rx_q.size(), 0);
        check(tx_q.size() == 0, "tx_queue_drained", tx_q.size(), 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         mism;
        int         busy_bad;
        logic [7:0] fb;
        logic       exp_bit;

        rst          = 1'b1;
        rx_drv       = 1'b1;
        loop_en      = 1'b0;
        bus.transmit = 1'b0;
        bus.tx_byte  = 8'h00;
        repeat (4) @(negedge clk);
        check(tx == 1'b1, "reset_tx", int'(tx), 1);
        check(bus.received == 1'b0, "reset_received", int'(bus.received), 0);
        check(bus.recv_error == 1'b0, "reset_recv_error", int'(bus.recv_error), 0);
        check(bus.rx_byte == 8'h00, "reset_rx_byte", int'(bus.rx_byte), 0);
        check(bus.is_receiving == 1'b0, "reset_is_receiving", int'(bus.is_receiving), 0);
        check(bus.is_transmitting == 1'b0, "reset_is_transmitting", int'(bus.is_transmitting), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Good frame 0xA5 with latency measurement from the falling edge
        fork
            send_rx(8'hA5, 1'b1, 20);
            begin
                n = 0;
                while (!bus.received && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                check(n >= 152 && n <= 158, "rx_latency", n, 155);
            end
        join

        // Framing error 0x3C, line held low three more bits
        fork
            send_rx(8'h3C, 1'b0, 8);
            begin
                repeat (200) @(negedge clk);
                check(bus.is_receiving == 1'b1, "rx_busy_in_break", int'(bus.is_receiving), 1);
            end
        join
        check(bus.is_receiving == 1'b0, "rx_idle_after_break", int'(bus.is_receiving), 0);
        check(bus.rx_byte == 8'hA5, "rx_byte_kept_after_error", int'(bus.rx_byte), 8'hA5);

        // Short glitch: abandoned at mid start bit, no pulse of any kind
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        check(bus.is_receiving == 1'b1, "glitch_start_seen", int'(bus.is_receiving), 1);
        rx_drv = 1'b1;
        repeat (10) @(negedge clk);
        check(bus.is_receiving == 1'b0, "glitch_rejected", int'(bus.is_receiving), 0);
        repeat (20) @(negedge clk);

        // TX 0x53 bit-exact, 0xFF mid-frame dropped, 0x00 back-to-back
        fb           = 8'h53;
        bus.transmit = 1'b1;
        bus.tx_byte  = fb;
        tx_q.push_back(fb);
        mism     = 0;
        busy_bad = 0;
        for (int k = 0; k < 160; k++) begin
            @(negedge clk);
            if (k == 0) bus.transmit = 1'b0;
            if (k == 40) begin
                bus.transmit = 1'b1;
                bus.tx_byte  = 8'hFF;
            end
            if (k == 41) bus.transmit = 1'b0;
            if (k < 16)       exp_bit = 1'b0;
            else if (k < 144) exp_bit = fb[(k / 16) - 1];
            else              exp_bit = 1'b1;
            if (tx !== exp_bit) mism++;
            if (bus.is_transmitting !== 1'b1) busy_bad++;
        end
        check(mism == 0, "tx_waveform_0x53", mism, 0);
        check(busy_bad == 0, "tx_busy_160_clks", busy_bad, 0);
        @(negedge clk);
        check(bus.is_transmitting == 1'b0, "tx_busy_drops", int'(bus.is_transmitting), 0);
        check(tx == 1'b1, "tx_idle_high", int'(tx), 1);
        bus.transmit = 1'b1;
        bus.tx_byte  = 8'h00;
        tx_q.push_back(8'h00);
        @(negedge clk);
        bus.transmit = 1'b0;
        check(tx == 1'b0, "tx_back_to_back_start", int'(tx), 0);
        check(bus.is_transmitting == 1'b1, "tx_back_to_back_busy", int'(bus.is_transmitting), 1);
        drain();

        // Randomised concurrent RX and TX traffic
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    send_rx(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
                            int'($urandom_range(4, 40)));
                end
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    do_tx(8'($urandom_range(0, 255)));
                    repeat ($urandom_range(0, 30)) @(negedge clk);
                end
            end
        join
        drain();

        // Loopback tx -> rx
        loop_en = 1'b1;
        do_tx(8'h00);
        do_tx(8'hFF);
        do_tx(8'($urandom_range(0, 255)));
        do_tx(8'($urandom_range(0, 255)));
        drain();
        loop_en = 1'b0;
        repeat (5) @(negedge clk);

        // Reset in the middle of a TX frame
        mon_en       = 1'b0;
        repeat (2) @(negedge clk);
        bus.transmit = 1'b1;
        bus.tx_byte  = 8'hC3;
        @(negedge clk);
        bus.transmit = 1'b0;
        repeat (50) @(negedge clk);
        check(bus.is_transmitting == 1'b1, "tx_busy_before_reset", int'(bus.is_transmitting), 1);
        rst = 1'b1;
        @(negedge clk);
        check(tx == 1'b1, "tx_after_reset", int'(tx), 1);
        check(bus.is_transmitting == 1'b0, "busy_after_reset", int'(bus.is_transmitting), 0);
        check(bus.rx_byte == 8'h00, "rx_byte_after_reset", int'(bus.rx_byte), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
